// File: rtl/serial_arithmetic_unit.sv
// rtl/serial_arithmetic_unit.sv - bit-serial add/subtract unit with start/busy/done handshake
module serial_arithmetic_unit #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carryIn,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] soma,
  output logic             carryOut,
  output logic             overflow,
  output logic             zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} stateT;

  stateT            state;
  stateT            stateNext;
  logic [WIDTH-1:0] shiftA;
  logic [WIDTH-1:0] shiftB;
  logic [WIDTH-1:0] shiftR;
  logic             carry;
  logic [CW-1:0]    bitCount;
  logic             accept;
  logic             sumBit;
  logic             sliceCarry;
  logic             lastBit;
  logic [WIDTH:0]   resultCat;
  logic [WIDTH-1:0] resultNext;

  // Single full-adder slice plus the result register as it looks after this bit.
  // The concatenate-then-slice form keeps the shift legal for WIDTH=1.
  always_comb begin
    sumBit     = shiftA[0] ^ shiftB[0] ^ carry;
    sliceCarry = (shiftA[0] & shiftB[0]) | (shiftA[0] & carry) | (shiftB[0] & carry);
    resultCat  = {sumBit, shiftR};
    resultNext = resultCat[WIDTH:1];
    lastBit    = (bitCount == LAST_BIT);
  end

  // State register; reset aborts any run without a clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state and handshake outputs; start is only honoured outside RUN.
  always_comb begin
    stateNext = state;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          stateNext = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (lastBit) begin
          stateNext = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept    = 1'b1;
          stateNext = RUN;
        end else begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Operand load, per-bit shifting, and result capture on the final bit.
  // Subtraction is folded into the load: invert B and the incoming borrow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shiftA   <= '0;
      shiftB   <= '0;
      shiftR   <= '0;
      carry    <= 1'b0;
      bitCount <= '0;
      soma     <= '0;
      carryOut <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else if (accept) begin
      shiftA   <= a;
      shiftB   <= op ? ~b : b;
      carry    <= carryIn ^ op;
      bitCount <= '0;
    end else if (state == RUN) begin
      shiftA   <= shiftA >> 1;
      shiftB   <= shiftB >> 1;
      shiftR   <= resultNext;
      carry    <= sliceCarry;
      bitCount <= bitCount + 1'b1;
      if (lastBit) begin
        soma     <= resultNext;
        carryOut <= sliceCarry;
        overflow <= sliceCarry ^ carry;
        zero     <= (resultNext == '0);
      end
    end
  end

endmodule

// File: tb/tb_serial_arithmetic_unit.sv
// tb/tb_serial_arithmetic_unit.sv - self-checking bench for serial_arithmetic_unit
`timescale 1ns/1ps
module tb_serial_arithmetic_unit;

  logic clk = 1'b0;
  logic reset;

  logic       start, op, carryIn;
  logic [5:0] a, b;
  logic       busy, done, carryOut, overflow, zero;
  logic [5:0] soma;

  logic start1, op1, carryIn1, a1, b1, busy1, done1, soma1, carryOut1, overflow1, zero1;

  logic        start32, op32, carryIn32, busy32, done32, carryOut32, overflow32, zero32;
  logic [31:0] a32, b32, soma32;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_arithmetic_unit #(.WIDTH(6)) u6 (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .carryIn(carryIn),
    .busy(busy), .done(done), .soma(soma), .carryOut(carryOut), .overflow(overflow), .zero(zero)
  );

  serial_arithmetic_unit #(.WIDTH(1)) u1 (
    .clk(clk), .reset(reset), .start(start1), .op(op1), .a(a1), .b(b1), .carryIn(carryIn1),
    .busy(busy1), .done(done1), .soma(soma1), .carryOut(carryOut1), .overflow(overflow1), .zero(zero1)
  );

  serial_arithmetic_unit #(.WIDTH(32)) u32 (
    .clk(clk), .reset(reset), .start(start32), .op(op32), .a(a32), .b(b32), .carryIn(carryIn32),
    .busy(busy32), .done(done32), .soma(soma32), .carryOut(carryOut32), .overflow(overflow32), .zero(zero32)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Arithmetic reference: plain integer add/subtract on unsigned and signed views.
  function automatic void compute(input int w, input bit o, input longint aa, input longint bb,
                                  input bit c, output longint s, output bit co, output bit ov,
                                  output bit z);
    longint m, sa, sb, full, sfull;
    m  = longint'(1) << w;
    sa = (aa >= m / 2) ? aa - m : aa;
    sb = (bb >= m / 2) ? bb - m : bb;
    if (!o) begin
      full  = aa + bb + longint'(c);
      co    = (full >= m);
      sfull = sa + sb + longint'(c);
    end else begin
      full  = aa - bb - longint'(c);
      co    = (full >= 0);
      sfull = sa - sb - longint'(c);
    end
    s  = (full + 2 * m) % m;
    ov = (sfull < -(m / 2)) || (sfull > m / 2 - 1);
    z  = (s == 0);
  endfunction

  // Transaction-level model of the 6-bit instance: an accepted start yields its
  // result exactly 6 edges later, starts are ignored while a result is pending.
  int     mRem;
  bit     mDone;
  longint mSoma, pSoma;
  bit     mCo, mOv, mZ, pCo, pOv, pZ;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mRem = 0; mDone = 0; mSoma = 0; mCo = 0; mOv = 0; mZ = 0;
    end else begin
      mDone = 0;
      if (mRem > 0) begin
        mRem--;
        if (mRem == 0) begin
          mDone = 1; mSoma = pSoma; mCo = pCo; mOv = pOv; mZ = pZ;
        end
      end else if (start) begin
        mRem = 6;
        compute(6, op, longint'(a), longint'(b), carryIn, pSoma, pCo, pOv, pZ);
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", busy, longint'(mRem > 0));
    chk("done", done, mDone);
    chk("soma", soma, mSoma);
    chk("carryOut", carryOut, mCo);
    chk("overflow", overflow, mOv);
    chk("zero", zero, mZ);
  end

  task automatic runOp(input bit o, input logic [5:0] aa, input logic [5:0] bb, input bit c,
                       input int pulseAt, input bit hold, output int lat);
    start = 1; op = o; a = aa; b = bb; carryIn = c;
    lat = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      start = hold || (cyc == pulseAt);
      a = 6'($urandom);
      b = 6'($urandom);
      if (done) begin
        lat = cyc - 1;
        break;
      end
    end
  endtask

  initial begin
    int lat, n;
    reset = 1; start = 0; op = 0; a = 0; b = 0; carryIn = 0;
    start1 = 0; op1 = 0; a1 = 0; b1 = 0; carryIn1 = 0;
    start32 = 0; op32 = 0; a32 = 0; b32 = 0; carryIn32 = 0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_soma", soma, 0);
    reset = 0;
    @(negedge clk);

    runOp(0, 6'b000110, 6'b000101, 0, 0, 0, lat);
    chk("t1_latency", lat, 6);
    chk("t1_soma", soma, 6'b001011);
    chk("t1_co", carryOut, 0);
    chk("t1_ov", overflow, 0);
    @(negedge clk);

    runOp(0, 6'b111100, 6'b000011, 1, 0, 0, lat);
    chk("t2_soma", soma, 0);
    chk("t2_co", carryOut, 1);
    chk("t2_zero", zero, 1);
    chk("t2_ov", overflow, 0);

    runOp(1, 6'b000101, 6'b000110, 0, 0, 0, lat);
    chk("t3_soma", soma, 6'b111111);
    chk("t3_co", carryOut, 0);
    chk("t3_ov", overflow, 0);

    runOp(1, 6'b100000, 6'b000001, 0, 0, 0, lat);
    chk("t4_soma", soma, 6'b011111);
    chk("t4_ov", overflow, 1);

    runOp(0, 6'b011111, 6'b000001, 0, 3, 0, lat);
    chk("t5_latency", lat, 6);
    chk("t5_soma", soma, 6'b100000);
    chk("t5_ov", overflow, 1);
    chk("t5_co", carryOut, 0);
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) n++;
    end
    chk("t5_extra_done", n, 0);

    runOp(0, 6'd2, 6'd3, 0, 0, 1, lat);
    chk("t6a_soma", soma, 5);
    op = 0; a = 6'd7; b = 6'd8; carryIn = 0;
    @(negedge clk);
    start = 0;
    chk("t6_busy_after_done", busy, 1);
    lat = 0;
    for (int i = 2; i <= 20; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i - 1;
        break;
      end
    end
    chk("t6b_latency", lat, 6);
    chk("t6b_soma", soma, 15);

    start = 1; op = 0; a = 6'd9; b = 6'd9; carryIn = 0;
    @(negedge clk);
    start = 0;
    repeat (2) @(negedge clk);
    #2 reset = 1;
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_done", done, 0);
    chk("rst_mid_soma", soma, 0);
    chk("rst_mid_co", carryOut, 0);
    chk("rst_mid_ov", overflow, 0);
    chk("rst_mid_zero", zero, 0);
    @(negedge clk);
    reset = 0;
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) n++;
    end
    chk("rst_no_done", n, 0);

    runOp(1, 6'd20, 6'd7, 1, 0, 0, lat);
    chk("t7_latency", lat, 6);
    chk("t7_soma", soma, 12);
    chk("t7_co", carryOut, 1);

    start1 = 1; a1 = 1; b1 = 1; carryIn1 = 0;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      start1 = 0;
      if (done1) begin
        lat = i - 1;
        break;
      end
    end
    compute(1, 0, 1, 1, 0, pSoma, pCo, pOv, pZ);
    chk("w1_latency", lat, 1);
    chk("w1_soma", soma1, 0);
    chk("w1_co", carryOut1, 1);
    chk("w1_ov", overflow1, pOv);
    chk("w1_zero", zero1, pZ);

    start32 = 1; a32 = 32'hFFFF_FFFF; b32 = 32'd1; carryIn32 = 0;
    lat = 0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      start32 = 0;
      if (done32) begin
        lat = i - 1;
        break;
      end
    end
    compute(32, 0, 64'hFFFF_FFFF, 1, 0, pSoma, pCo, pOv, pZ);
    chk("w32_latency", lat, 32);
    chk("w32_soma", soma32, 0);
    chk("w32_co", carryOut32, 1);
    chk("w32_zero", zero32, 1);
    chk("w32_ov", overflow32, pOv);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
